// File: rtl/micro_sequencer.sv
// Microprogram counter and next-address selection for the control unit.
// Holds the registered microcode ROM address and the IDLE/RUN/HALT sequencing state.
module micro_sequencer #(
   parameter int ADDR_W     = 8,
   parameter int FETCH_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stall,
   input  logic [15:0]       map_addr,
   input  logic [2:0]        next_sel,
   input  logic [ADDR_W-1:0] br_addr,
   input  logic              z_flag,
   output logic [ADDR_W-1:0] upc,
   output logic              running,
   output logic              halted,
   output logic              seq_err,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] FETCH = ADDR_W'(FETCH_ADDR);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] upc_q, upc_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] upc_inc;
   logic              inc_wraps;
   logic              map_oob;

   assign upc_inc   = upc_q + 1'b1;
   assign inc_wraps = &upc_q;
   // Entry addresses wider than the ROM are treated as a mapping fault.
   assign map_oob   = (map_addr >> ADDR_W) != 16'd0;

   always_comb begin
      state_d = state_q;
      upc_d   = upc_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d = S_RUN;
               upc_d   = FETCH;
            end
         end
         S_RUN: begin
            if (!stall) begin
               case (next_sel)
                  3'd0: begin
                     upc_d = upc_inc;
                     if (inc_wraps) err_d = 1'b1;
                  end
                  3'd1: begin
                     if (map_oob) begin
                        upc_d = FETCH;
                        err_d = 1'b1;
                     end else begin
                        upc_d = map_addr[ADDR_W-1:0];
                     end
                  end
                  3'd2: upc_d = FETCH;
                  3'd3: upc_d = br_addr;
                  3'd4, 3'd5: begin
                     // BRZ takes on z_flag=1, BRNZ on z_flag=0.
                     if (z_flag == (next_sel == 3'd4)) begin
                        upc_d = br_addr;
                     end else begin
                        upc_d = upc_inc;
                        if (inc_wraps) err_d = 1'b1;
                     end
                  end
                  3'd6: state_d = S_HALT;
                  default: begin
                     upc_d = upc_inc;
                     err_d = 1'b1;
                  end
               endcase
            end
         end
         default: begin
            state_d = S_IDLE;
            upc_d   = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         upc_q   <= FETCH;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         upc_q   <= upc_d;
         err_q   <= err_d;
      end
   end

   assign upc       = upc_q;
   assign running   = (state_q == S_RUN);
   assign halted    = (state_q == S_HALT);
   assign seq_err   = err_q;
   assign dbg_state = state_q;

endmodule
